// File: rtl/pcie_dll_rx_if.sv
// pcie_dll_rx_if: bundles the frame input, TLP output and Ack/Nak request
// channels of the DLL receive stage, plus a debug view of the scheduler state.
// Optional error counters appear when PCIE_DLL_RX_ERR_CNT_EN is defined.
//
// Handshake rule for all three channels: a transfer happens on the rising clock
// edge where valid and ready are both 1. A source holds valid and its data stable
// until that edge. Ready may depend combinationally on the sink's own state.
interface pcie_dll_rx_if #(
  parameter int TLP_W = 224
) ();
  logic                 dll_valid_i;
  logic [TLP_W+47:0]    dll_frame_i;
  logic                 dll_ready_o;
  logic                 tlp_valid_o;
  logic [TLP_W-1:0]     tlp_o;
  logic                 tlp_ready_i;
  logic                 ack_valid_o;
  logic                 ack_nak_o;
  logic [11:0]          ack_seq_o;
  logic                 ack_ready_i;
  logic [1:0]           dbg_state_o;
`ifdef PCIE_DLL_RX_ERR_CNT_EN
  logic [15:0]          lcrc_err_cnt_o;
  logic [15:0]          seq_err_cnt_o;
  logic [15:0]          dup_cnt_o;

  modport slave (
    input  dll_valid_i, dll_frame_i, tlp_ready_i, ack_ready_i,
    output dll_ready_o, tlp_valid_o, tlp_o, ack_valid_o, ack_nak_o, ack_seq_o,
           dbg_state_o, lcrc_err_cnt_o, seq_err_cnt_o, dup_cnt_o
  );
  modport master (
    output dll_valid_i, dll_frame_i, tlp_ready_i, ack_ready_i,
    input  dll_ready_o, tlp_valid_o, tlp_o, ack_valid_o, ack_nak_o, ack_seq_o,
           dbg_state_o, lcrc_err_cnt_o, seq_err_cnt_o, dup_cnt_o
  );
`else
  modport slave (
    input  dll_valid_i, dll_frame_i, tlp_ready_i, ack_ready_i,
    output dll_ready_o, tlp_valid_o, tlp_o, ack_valid_o, ack_nak_o, ack_seq_o,
           dbg_state_o
  );
  modport master (
    output dll_valid_i, dll_frame_i, tlp_ready_i, ack_ready_i,
    input  dll_ready_o, tlp_valid_o, tlp_o, ack_valid_o, ack_nak_o, ack_seq_o,
           dbg_state_o
  );
`endif
endinterface

// File: rtl/pcie_dll_rx.sv
// pcie_dll_rx: Data Link Layer receive stage. Checks LCRC and sequence number
// of incoming frames, forwards good TLPs through a one-entry output register,
// and schedules Ack/Nak DLLPs with coalescing, timeout and Nak-once behaviour.
// Optional macro PCIE_DLL_RX_ERR_CNT_EN adds saturating LCRC-error,
// sequence-error and duplicate counters on the interface.
module pcie_dll_rx #(
  parameter int TLP_W        = 224,
  parameter int ACK_COALESCE = 4,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  pcie_dll_rx_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_SEND = 2'd2
  } state_t;

  // CRC-32 (poly 0x04C11DB7, init all-ones) shifted MSB-first, result inverted
  function automatic logic [31:0] f_crc(input logic [TLP_W+15:0] d);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = TLP_W + 15; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return ~c;
  endfunction

  state_t           r_state;
  logic [11:0]      r_next_seq;
  logic             r_nak_sched;
  logic [7:0]       r_pend_cnt;
  logic [9:0]       r_timer;
  logic             r_q_nak;
  logic             r_q_ack;
  logic             r_tlp_valid;
  logic [TLP_W-1:0] r_tlp;
  logic             r_ack_valid;
  logic             r_ack_nak;
  logic [11:0]      r_ack_seq;

  logic             w_dll_ready;
  logic             w_accept;
  logic             w_crc_ok;
  logic [11:0]      w_seq;
  logic [11:0]      w_dist;
  logic             w_good;
  logic             w_dup;
  logic             w_ahead;
  logic             w_nak_req;
  logic [11:0]      w_next_seq_n;
  logic [11:0]      w_ack_seq;
  logic [7:0]       w_pend_n;
  logic             w_coal_hit;
  logic             w_enter_send;
  logic             w_enter_nak;

  assign w_dll_ready  = !r_tlp_valid || bus.tlp_ready_i;
  assign w_accept     = bus.dll_valid_i && w_dll_ready;
  assign w_crc_ok     = (f_crc(bus.dll_frame_i[TLP_W+47:32]) == bus.dll_frame_i[31:0]);
  assign w_seq        = bus.dll_frame_i[TLP_W+43:TLP_W+32];
  assign w_dist       = r_next_seq - w_seq;
  assign w_good       = w_accept && w_crc_ok && (w_dist == 12'd0);
  assign w_dup        = w_accept && w_crc_ok && (w_dist != 12'd0) && (w_dist <= 12'd2048);
  assign w_ahead      = w_accept && w_crc_ok && (w_dist > 12'd2048);
  // A bad or out-of-order frame asks for a Nak only once until a good frame arrives
  assign w_nak_req    = ((w_accept && !w_crc_ok) || w_ahead) && !r_nak_sched;
  // Ack seq reflects a good frame accepted on the same edge
  assign w_next_seq_n = r_next_seq + {11'd0, w_good};
  assign w_ack_seq    = w_next_seq_n - 12'd1;
  assign w_pend_n     = (w_good && r_pend_cnt != 8'hFF) ? r_pend_cnt + 8'd1 : r_pend_cnt;
  assign w_coal_hit   = (w_pend_n >= 8'(ACK_COALESCE));

  assign bus.dll_ready_o = w_dll_ready;
  assign bus.tlp_valid_o = r_tlp_valid;
  assign bus.tlp_o       = r_tlp;
  assign bus.ack_valid_o = r_ack_valid;
  assign bus.ack_nak_o   = r_ack_nak;
  assign bus.ack_seq_o   = r_ack_seq;
  assign bus.dbg_state_o = r_state;

  // Decide whether the scheduler (re)enters SEND this cycle and with which type
  always_comb begin
    w_enter_send = 1'b0;
    w_enter_nak  = 1'b0;
    case (r_state)
      S_IDLE, S_PEND: begin
        w_enter_send = w_nak_req || w_dup || w_coal_hit ||
                       (r_state == S_PEND && r_timer == 10'(ACK_TIMEOUT - 1));
        w_enter_nak  = w_nak_req;
      end
      S_SEND: begin
        w_enter_send = bus.ack_ready_i && (r_q_nak || w_nak_req || r_q_ack || w_dup);
        w_enter_nak  = r_q_nak || w_nak_req;
      end
      default: begin
        w_enter_send = 1'b0;
        w_enter_nak  = 1'b0;
      end
    endcase
  end

  // Receive sequence tracking and Nak-once flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_seq  <= 12'd0;
      r_nak_sched <= 1'b0;
    end else begin
      r_next_seq <= w_next_seq_n;
      if (w_good)         r_nak_sched <= 1'b0;
      else if (w_nak_req) r_nak_sched <= 1'b1;
    end
  end

  // One-entry TLP output register; a good frame always loads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tlp_valid <= 1'b0;
      r_tlp       <= '0;
    end else if (w_good) begin
      r_tlp_valid <= 1'b1;
      r_tlp       <= bus.dll_frame_i[TLP_W+31:32];
    end else if (bus.tlp_ready_i) begin
      r_tlp_valid <= 1'b0;
    end
  end

  // Ack/Nak scheduler: coalesce, time out, queue events while a DLLP is pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pend_cnt  <= 8'd0;
      r_timer     <= 10'd0;
      r_q_nak     <= 1'b0;
      r_q_ack     <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_nak   <= 1'b0;
      r_ack_seq   <= 12'd0;
    end else if (w_enter_send) begin
      r_state     <= S_SEND;
      r_ack_valid <= 1'b1;
      r_ack_nak   <= w_enter_nak;
      r_ack_seq   <= w_ack_seq;
      r_pend_cnt  <= 8'd0;
      r_timer     <= 10'd0;
      r_q_nak     <= 1'b0;
      r_q_ack     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_good) begin
            r_state    <= S_PEND;
            r_pend_cnt <= w_pend_n;
            r_timer    <= 10'd0;
          end
        end
        S_PEND: begin
          r_pend_cnt <= w_pend_n;
          r_timer    <= r_timer + 10'd1;
        end
        S_SEND: begin
          r_pend_cnt <= w_pend_n;
          if (bus.ack_ready_i) begin
            r_ack_valid <= 1'b0;
            r_timer     <= 10'd0;
            r_state     <= (w_pend_n != 8'd0) ? S_PEND : S_IDLE;
          end else begin
            r_q_nak <= r_q_nak || w_nak_req;
            r_q_ack <= r_q_ack || w_dup;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef PCIE_DLL_RX_ERR_CNT_EN
  logic [15:0] r_lcrc_err_cnt;
  logic [15:0] r_seq_err_cnt;
  logic [15:0] r_dup_cnt;

  assign bus.lcrc_err_cnt_o = r_lcrc_err_cnt;
  assign bus.seq_err_cnt_o  = r_seq_err_cnt;
  assign bus.dup_cnt_o      = r_dup_cnt;

  // Saturating counters per discarded-frame class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lcrc_err_cnt <= 16'd0;
      r_seq_err_cnt  <= 16'd0;
      r_dup_cnt      <= 16'd0;
    end else begin
      if (w_accept && !w_crc_ok && r_lcrc_err_cnt != 16'hFFFF) r_lcrc_err_cnt <= r_lcrc_err_cnt + 16'd1;
      if (w_ahead && r_seq_err_cnt != 16'hFFFF)                r_seq_err_cnt  <= r_seq_err_cnt + 16'd1;
      if (w_dup && r_dup_cnt != 16'hFFFF)                      r_dup_cnt      <= r_dup_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_dll_rx.sv
// tb_pcie_dll_rx: directed bench for pcie_dll_rx (TLP_W=224, ACK_COALESCE=4,
// ACK_TIMEOUT=64). Frames carry LCRCs from a byte-wise CRC-32 model.
module tb_pcie_dll_rx;

  localparam int TLP_W = 224;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   n_ack_hs;
  int   n_nak_hs;
  logic [TLP_W-1:0] exp_q[$];
  logic [TLP_W-1:0] last_tlp;

  pcie_dll_rx_if #(.TLP_W(TLP_W)) bus ();

  pcie_dll_rx #(.TLP_W(TLP_W), .ACK_COALESCE(4), .ACK_TIMEOUT(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // byte-at-a-time CRC-32, MSB-first, init all-ones, inverted result
  function automatic logic [31:0] crc_bytes(input logic [255:0] d, input int nbytes);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFF_FFFF;
    for (int i = nbytes - 1; i >= 0; i--) begin
      b = d[i*8 +: 8];
      c = c ^ {b, 24'h0};
      for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
    end
    return ~c;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // drive one frame and wait for it to be accepted; called at a negedge
  task automatic send_frame(input logic [11:0] seq, input bit bad, input bit fwd);
    logic [TLP_W-1:0] t;
    logic [239:0]     body;
    logic [31:0]      crc;
    int               guard;
    for (int k = 0; k < 7; k++) t[k*32 +: 32] = $urandom();
    body = {4'h0, seq, t};
    crc  = crc_bytes({16'h0, body}, 30);
    last_tlp = t;
    if (fwd) exp_q.push_back(t);
    bus.dll_frame_i = {body, crc ^ {31'h0, bad}};
    bus.dll_valid_i = 1'b1;
    guard = 0;
    forever begin
      #1;
      if (bus.dll_ready_o) break;
      @(negedge clk);
      guard++;
      if (guard > 1000) begin
        chk("accept_timeout", 1, 0);
        break;
      end
    end
    @(negedge clk);
    bus.dll_valid_i = 1'b0;
    if (fwd) begin
      chk("fwd_valid", bus.tlp_valid_o, 1);
      chk("fwd_data", bus.tlp_o, t);
    end
  endtask

  // scoreboard: TLP transfers against expected queue, DLLP transfer counts
  always @(negedge clk) begin
    #1;
    if (rst_n && bus.tlp_valid_o && bus.tlp_ready_i) begin
      if (exp_q.size() == 0) chk("tlp_unexpected", 1, 0);
      else chk("tlp_order", bus.tlp_o, exp_q.pop_front());
    end
    if (rst_n && bus.ack_valid_o && bus.ack_ready_i) begin
      n_ack_hs++;
      if (bus.ack_nak_o) n_nak_hs++;
    end
  end

  initial begin
    logic [255:0]     vec;
    logic [TLP_W-1:0] t0;
    int               cnt;
    int               base_ack;
    int               base_nak;
    n_checks = 0; n_fail = 0; n_ack_hs = 0; n_nak_hs = 0;
    bus.dll_valid_i = 1'b0;
    bus.dll_frame_i = '0;
    bus.tlp_ready_i = 1'b1;
    bus.ack_ready_i = 1'b1;
    rst_n = 1'b0;

    // CRC model sanity: CRC-32/BZIP2 of "123456789"
    vec = 256'("123456789");
    chk("crc_model", crc_bytes(vec, 9), 32'hFC89_1918);

    // reset state
    do_reset();
    chk("rst_tlp_valid", bus.tlp_valid_o, 0);
    chk("rst_tlp", bus.tlp_o, 0);
    chk("rst_ack_valid", bus.ack_valid_o, 0);
    chk("rst_ack_nak", bus.ack_nak_o, 0);
    chk("rst_ack_seq", bus.ack_seq_o, 0);
    chk("rst_dll_ready", bus.dll_ready_o, 1);
    chk("rst_state", bus.dbg_state_o, 0);

    // four in-order frames: coalesced Ack right after the 4th
    for (int i = 0; i < 4; i++) send_frame(12'(i), 1'b0, 1'b1);
    chk("coal_ack_valid", bus.ack_valid_o, 1);
    chk("coal_ack_nak", bus.ack_nak_o, 0);
    chk("coal_ack_seq", bus.ack_seq_o, 3);
    @(negedge clk);
    chk("coal_ack_done", bus.ack_valid_o, 0);
    chk("coal_expq", exp_q.size(), 0);

    // single frame then idle: Ack after timeout, held until ready
    do_reset();
    bus.ack_ready_i = 1'b0;
    send_frame(12'd0, 1'b0, 1'b1);
    cnt = 0;
    while (!bus.ack_valid_o && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("tmo_latency", cnt, 64);
    repeat (5) @(negedge clk);
    chk("tmo_hold_valid", bus.ack_valid_o, 1);
    chk("tmo_hold_nak", bus.ack_nak_o, 0);
    chk("tmo_hold_seq", bus.ack_seq_o, 0);
    bus.ack_ready_i = 1'b1;
    @(negedge clk);
    chk("tmo_released", bus.ack_valid_o, 0);
    chk("tmo_state_idle", bus.dbg_state_o, 0);

    // LCRC error: one Nak only, then recovery
    do_reset();
    base_nak = n_nak_hs;
    send_frame(12'd0, 1'b0, 1'b1);
    send_frame(12'd1, 1'b1, 1'b0);
    chk("nak_valid", bus.ack_valid_o, 1);
    chk("nak_type", bus.ack_nak_o, 1);
    chk("nak_seq", bus.ack_seq_o, 0);
    send_frame(12'd1, 1'b1, 1'b0);
    chk("nak_once", bus.ack_valid_o, 0);
    send_frame(12'd1, 1'b0, 1'b1);
    send_frame(12'd2, 1'b1, 1'b0);
    chk("nak2_type", bus.ack_nak_o, 1);
    chk("nak2_seq", bus.ack_seq_o, 1);
    repeat (3) @(negedge clk);
    chk("nak_count", n_nak_hs - base_nak, 2);
    chk("nak_expq", exp_q.size(), 0);
`ifdef PCIE_DLL_RX_ERR_CNT_EN
    chk("lcrc_err_cnt", bus.lcrc_err_cnt_o, 3);
`endif

    // duplicate then ahead, starting from next_rcv_seq=5
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(12'(i), 1'b0, 1'b1);
    send_frame(12'd3, 1'b0, 1'b0);
    chk("dup_ack_valid", bus.ack_valid_o, 1);
    chk("dup_ack_nak", bus.ack_nak_o, 0);
    chk("dup_ack_seq", bus.ack_seq_o, 4);
    send_frame(12'd9, 1'b0, 1'b0);
    chk("ahead_nak_valid", bus.ack_valid_o, 1);
    chk("ahead_nak", bus.ack_nak_o, 1);
    chk("ahead_nak_seq", bus.ack_seq_o, 4);
    repeat (3) @(negedge clk);
    chk("dupahead_expq", exp_q.size(), 0);
    chk("dupahead_tlp_idle", bus.tlp_valid_o, 0);
`ifdef PCIE_DLL_RX_ERR_CNT_EN
    chk("dup_cnt", bus.dup_cnt_o, 1);
    chk("seq_err_cnt", bus.seq_err_cnt_o, 1);
`endif

    // sequence wrap over 4100 frames
    do_reset();
    base_ack = n_ack_hs;
    base_nak = n_nak_hs;
    for (int i = 0; i < 4100; i++) send_frame(12'(i), 1'b0, 1'b1);
    chk("wrap_ack_valid", bus.ack_valid_o, 1);
    chk("wrap_ack_nak", bus.ack_nak_o, 0);
    chk("wrap_ack_seq", bus.ack_seq_o, 3);
    repeat (2) @(negedge clk);
    chk("wrap_ack_count", n_ack_hs - base_ack, 1025);
    chk("wrap_nak_count", n_nak_hs - base_nak, 0);
    chk("wrap_expq", exp_q.size(), 0);

    // backpressure for 10 cycles with a frame waiting
    do_reset();
    bus.ack_ready_i = 1'b0;
    bus.tlp_ready_i = 1'b0;
    send_frame(12'd0, 1'b0, 1'b1);
    t0 = last_tlp;
    fork
      send_frame(12'd1, 1'b0, 1'b1);
      begin
        repeat (10) begin
          @(negedge clk);
          #2;
          chk("bp_dll_ready", bus.dll_ready_o, 0);
          chk("bp_tlp_stable", bus.tlp_o, t0);
        end
        @(negedge clk);
        bus.tlp_ready_i = 1'b1;
      end
    join
    send_frame(12'd2, 1'b0, 1'b1);
    send_frame(12'd3, 1'b0, 1'b1);
    chk("bp_ack_valid", bus.ack_valid_o, 1);
    chk("bp_ack_seq", bus.ack_seq_o, 3);
    repeat (2) @(negedge clk);
    chk("bp_expq", exp_q.size(), 0);

    // reset while an Ack is pending
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tlp_valid", bus.tlp_valid_o, 0);
    chk("mid_rst_tlp", bus.tlp_o, 0);
    chk("mid_rst_ack_valid", bus.ack_valid_o, 0);
    chk("mid_rst_ack_nak", bus.ack_nak_o, 0);
    chk("mid_rst_ack_seq", bus.ack_seq_o, 0);
    chk("mid_rst_dll_ready", bus.dll_ready_o, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.ack_ready_i = 1'b1;
    base_nak = n_nak_hs;
    send_frame(12'd0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("post_rst_expq", exp_q.size(), 0);
    chk("post_rst_no_nak", n_nak_hs - base_nak, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
